adc_result_reader: RTL and testbench

- Host-side counterpart of the SAR-ADC digital core, running in the system clock domain.
- Drives the core's two 16-bit configuration words and its reset.
- Synchronises the core's conversion-finished strobe and captures each 16-bit result into a small first-word-fall-through FIFO.
- Presents buffered results to the host on a valid/ready read port, with overflow and sample-count status.

---
 rtl/adc_result_reader.sv | 155 +++++++++++++++
 tb/tb_adc_result_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_result_reader.sv
// Host-side reader for the SAR-ADC core: drives its config words and reset,
// synchronises the conversion strobe and buffers results in a FWFT FIFO.
module adc_result_reader #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int ADC_RST_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          conv_finished_in,
    input  logic [DATA_WIDTH-1:0]         result_in,
    input  logic                          cfg_wr_en_in,
    input  logic                          cfg_addr_in,
    input  logic [DATA_WIDTH-1:0]         cfg_wdata_in,
    output logic [DATA_WIDTH-1:0]         config_1_out,
    output logic [DATA_WIDTH-1:0]         config_2_out,
    output logic                          adc_rst_n_out,
    input  logic                          clear_in,
    input  logic                          rd_ready_in,
    output logic                          rd_valid_out,
    output logic [DATA_WIDTH-1:0]         rd_data_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out,
    output logic [15:0]                   sample_count_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(ADC_RST_CYCLES + 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(ADC_RST_CYCLES);

    typedef enum logic {
        HOLD,
        RUN
    } seq_state_t;

    seq_state_t state, next_state;
    logic [CNT_W-1:0] hold_cnt;

    logic [DATA_WIDTH-1:0] cfg_1, cfg_2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed_q;
    logic                   push;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic [15:0]           sample_count;
    logic                  fifo_full, fifo_valid, pop, accept, do_pop, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_1 <= '0;
            cfg_2 <= '0;
        end else if (cfg_wr_en_in) begin
            if (cfg_addr_in) cfg_2 <= cfg_wdata_in;
            else             cfg_1 <= cfg_wdata_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HOLD;
        else     state <= next_state;
    end

    // Any config write reloads the hold count, restarting a hold in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= RST_LOAD;
        else if (cfg_wr_en_in)
            hold_cnt <= RST_LOAD;
        else if (state == HOLD && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
    end

    always_comb begin
        next_state = state;
        case (state)
            HOLD:    if (hold_cnt <= CNT_W'(1)) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = HOLD;
        endcase
        if (cfg_wr_en_in) next_state = HOLD;
    end

    always_comb begin
        adc_rst_n_out = 1'b0;
        if (state == RUN) adc_rst_n_out = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            delayed_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], conv_finished_in};
            delayed_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign push = sync_q[SYNC_STAGES-1] & ~delayed_q & adc_rst_n_out;

    assign fifo_full  = (level == FULL_LEVEL);
    assign fifo_valid = (level != '0);
    assign pop        = fifo_valid & rd_ready_in;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign accept     = push & (~fifo_full | pop) & ~clear_in;
    assign do_pop     = pop & ~clear_in;
    assign drop       = push & fifo_full & ~pop & ~clear_in;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= result_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            sample_count <= '0;
        end else if (clear_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            sample_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr       <= wr_ptr + 1'b1;
                sample_count <= sample_count + 16'd1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop)   overflow <= 1'b1;
            case ({accept, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign config_1_out     = cfg_1;
    assign config_2_out     = cfg_2;
    assign rd_valid_out     = fifo_valid;
    assign rd_data_out      = fifo_valid ? mem[rd_ptr] : '0;
    assign fifo_level_out   = level;
    assign overflow_out     = overflow;
    assign sample_count_out = sample_count;

endmodule

// File: tb/tb_adc_result_reader.sv
// Directed self-checking bench for adc_result_reader with hand-computed
// expected values; inputs change and outputs are sampled on the falling edge.
module tb_adc_result_reader;

    logic        clk;
    logic        rst;
    logic        conv_finished_in;
    logic [15:0] result_in;
    logic        cfg_wr_en_in;
    logic        cfg_addr_in;
    logic [15:0] cfg_wdata_in;
    logic [15:0] config_1_out;
    logic [15:0] config_2_out;
    logic        adc_rst_n_out;
    logic        clear_in;
    logic        rd_ready_in;
    logic        rd_valid_out;
    logic [15:0] rd_data_out;
    logic [2:0]  fifo_level_out;
    logic        overflow_out;
    logic [15:0] sample_count_out;

    int check_count = 0;
    int error_count = 0;

    adc_result_reader #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4),
        .SYNC_STAGES(2),
        .ADC_RST_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .conv_finished_in(conv_finished_in),
        .result_in(result_in),
        .cfg_wr_en_in(cfg_wr_en_in),
        .cfg_addr_in(cfg_addr_in),
        .cfg_wdata_in(cfg_wdata_in),
        .config_1_out(config_1_out),
        .config_2_out(config_2_out),
        .adc_rst_n_out(adc_rst_n_out),
        .clear_in(clear_in),
        .rd_ready_in(rd_ready_in),
        .rd_valid_out(rd_valid_out),
        .rd_data_out(rd_data_out),
        .fifo_level_out(fifo_level_out),
        .overflow_out(overflow_out),
        .sample_count_out(sample_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One strobe two cycles wide, then enough idle for the sync chain to settle.
    task automatic applyStimulus(input logic [15:0] value);
        result_in        = value;
        conv_finished_in = 1'b1;
        repeat (2) tick();
        conv_finished_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic cfgWrite(input logic addr, input logic [15:0] data);
        cfg_wr_en_in = 1'b1;
        cfg_addr_in  = addr;
        cfg_wdata_in = data;
        tick();
        cfg_wr_en_in = 1'b0;
    endtask

    task automatic pulseClear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        conv_finished_in = 1'b0;
        result_in        = '0;
        cfg_wr_en_in     = 1'b0;
        cfg_addr_in      = 1'b0;
        cfg_wdata_in     = '0;
        clear_in         = 1'b0;
        rd_ready_in      = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_cfg1", config_1_out, 0);
        checkOutput("rst_cfg2", config_2_out, 0);
        checkOutput("rst_adc_rst_n", adc_rst_n_out, 0);
        checkOutput("rst_valid", rd_valid_out, 0);
        checkOutput("rst_data", rd_data_out, 0);
        checkOutput("rst_level", fifo_level_out, 0);
        checkOutput("rst_ovf", overflow_out, 0);
        checkOutput("rst_count", sample_count_out, 0);

        // Reset release: four low cycles, high from the fifth.
        rst = 1'b0;
        checkOutput("rel_low0", adc_rst_n_out, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("rel_low%0d", i), adc_rst_n_out, 0);
        end
        tick();
        checkOutput("rel_high", adc_rst_n_out, 1);
        checkOutput("rel_valid", rd_valid_out, 0);

        // Config write in RUN, with a strobe arriving during the hold.
        cfgWrite(1'b0, 16'h002B);
        checkOutput("cfg1_val", config_1_out, 16'h002B);
        checkOutput("cfg1_low0", adc_rst_n_out, 0);
        result_in        = 16'hDEAD;
        conv_finished_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("cfg1_low%0d", i), adc_rst_n_out, 0);
        end
        tick();
        checkOutput("cfg1_high", adc_rst_n_out, 1);
        conv_finished_in = 1'b0;
        repeat (3) tick();
        checkOutput("hold_no_push", fifo_level_out, 0);

        // Second write restarts a hold already in progress.
        cfgWrite(1'b1, 16'h1111);
        repeat (2) tick();
        cfgWrite(1'b1, 16'h1234);
        checkOutput("cfg2_val", config_2_out, 16'h1234);
        checkOutput("cfg1_kept", config_1_out, 16'h002B);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("cfg2_low%0d", i), adc_rst_n_out, 0);
        end
        tick();
        checkOutput("cfg2_high", adc_rst_n_out, 1);

        // Three results buffered, then drained in order.
        applyStimulus(16'h0100);
        applyStimulus(16'h0200);
        applyStimulus(16'h0300);
        checkOutput("three_level", fifo_level_out, 3);
        checkOutput("three_valid", rd_valid_out, 1);
        checkOutput("three_head", rd_data_out, 16'h0100);
        rd_ready_in = 1'b1;
        tick();
        checkOutput("read2", rd_data_out, 16'h0200);
        tick();
        checkOutput("read3", rd_data_out, 16'h0300);
        tick();
        rd_ready_in = 1'b0;
        checkOutput("drained_valid", rd_valid_out, 0);
        checkOutput("drained_data", rd_data_out, 0);
        checkOutput("drained_level", fifo_level_out, 0);
        checkOutput("three_count", sample_count_out, 3);

        // Overflow: five strobes into a depth-4 FIFO.
        pulseClear();
        checkOutput("clr_count", sample_count_out, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(16'(i));
        checkOutput("ovf_level", fifo_level_out, 4);
        checkOutput("ovf_flag", overflow_out, 1);
        checkOutput("ovf_count", sample_count_out, 4);
        rd_ready_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("ovf_entry%0d", i), rd_data_out, i);
            tick();
        end
        rd_ready_in = 1'b0;
        checkOutput("ovf_empty", rd_valid_out, 0);
        checkOutput("ovf_sticky", overflow_out, 1);

        // Push with a coincident pop while full.
        pulseClear();
        for (int i = 0; i < 4; i++) applyStimulus(16'h0011 + 16'(i));
        checkOutput("full_level", fifo_level_out, 4);
        result_in        = 16'h0015;
        conv_finished_in = 1'b1;
        repeat (2) tick();
        rd_ready_in = 1'b1;
        tick();
        rd_ready_in = 1'b0;
        checkOutput("pp_level", fifo_level_out, 4);
        checkOutput("pp_ovf", overflow_out, 0);
        checkOutput("pp_count", sample_count_out, 5);
        checkOutput("pp_head", rd_data_out, 16'h0012);
        conv_finished_in = 1'b0;
        repeat (3) tick();

        // Long strobe yields a single entry within three cycles of the rise.
        pulseClear();
        result_in        = 16'hABCD;
        conv_finished_in = 1'b1;
        repeat (3) tick();
        checkOutput("long_first", fifo_level_out, 1);
        repeat (17) tick();
        checkOutput("long_level", fifo_level_out, 1);
        conv_finished_in = 1'b0;
        repeat (3) tick();
        checkOutput("long_final", fifo_level_out, 1);
        checkOutput("long_data", rd_data_out, 16'hABCD);
        checkOutput("long_count", sample_count_out, 1);
        rd_ready_in = 1'b1;
        tick();
        rd_ready_in = 1'b0;
        checkOutput("long_popped", fifo_level_out, 0);

        // Push into an empty FIFO while ready is high: pop is ignored that edge.
        rd_ready_in      = 1'b1;
        result_in        = 16'h5A5A;
        conv_finished_in = 1'b1;
        repeat (3) tick();
        checkOutput("ep_level", fifo_level_out, 1);
        checkOutput("ep_data", rd_data_out, 16'h5A5A);
        tick();
        checkOutput("ep_popped", fifo_level_out, 0);
        rd_ready_in      = 1'b0;
        conv_finished_in = 1'b0;
        repeat (3) tick();

        // Clear coincident with a push while overflow is set.
        for (int i = 0; i < 5; i++) applyStimulus(16'h0021 + 16'(i));
        checkOutput("pre_clr_ovf", overflow_out, 1);
        result_in        = 16'h7777;
        conv_finished_in = 1'b1;
        repeat (2) tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        checkOutput("cp_level", fifo_level_out, 0);
        checkOutput("cp_ovf", overflow_out, 0);
        checkOutput("cp_count", sample_count_out, 0);
        checkOutput("cp_cfg1", config_1_out, 16'h002B);
        conv_finished_in = 1'b0;
        repeat (3) tick();
        checkOutput("cp_after", fifo_level_out, 0);

        // Asynchronous reset in the middle of operation.
        applyStimulus(16'h0031);
        applyStimulus(16'h0032);
        checkOutput("mid_level", fifo_level_out, 2);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_cfg1", config_1_out, 0);
        checkOutput("mid_cfg2", config_2_out, 0);
        checkOutput("mid_adc_rst_n", adc_rst_n_out, 0);
        checkOutput("mid_valid", rd_valid_out, 0);
        checkOutput("mid_data", rd_data_out, 0);
        checkOutput("mid_level0", fifo_level_out, 0);
        checkOutput("mid_ovf", overflow_out, 0);
        checkOutput("mid_count", sample_count_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
